// File: rtl/i2c_arbiter_if.sv
// Bundle of requester-side and engine-side signals of the shared i2c byte-engine arbiter.
// Handshake: req_valid[i] is raised with req_rw/req_data stable and held until rsp_valid[i] pulses;
// rsp_valid is a single-cycle pulse with no back-pressure, and rsp_data/rsp_nack/rsp_err are valid with it.
interface i2c_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_rw;
    logic [NREQ*16-1:0] req_data;
    logic [NREQ-1:0]    rsp_valid;
    logic [7:0]         rsp_data;
    logic               rsp_nack;
    logic               rsp_err;
    logic               busy;
    logic               eng_startread;
    logic               eng_startwrite;
    logic               eng_rw;
    logic [15:0]        eng_data;
    logic               eng_done;
    logic               eng_ack;
    logic [7:0]         eng_data_out;

    // master = requesters plus the byte engine; slave = the arbiter itself
    modport master (
        output req_valid, req_rw, req_data, eng_done, eng_ack, eng_data_out,
        input  rsp_valid, rsp_data, rsp_nack, rsp_err, busy,
               eng_startread, eng_startwrite, eng_rw, eng_data
    );

    modport slave (
        input  req_valid, req_rw, req_data, eng_done, eng_ack, eng_data_out,
        output rsp_valid, rsp_data, rsp_nack, rsp_err, busy,
               eng_startread, eng_startwrite, eng_rw, eng_data
    );
endinterface

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one i2c byte engine among NREQ requesters.
// Optional eng_done watchdog is enabled by defining I2C_TIMEOUT_EN.
module i2c_arbiter #(
    parameter int NREQ        = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic              clk,
    input  logic              reset,
    i2c_arbiter_if.slave      bus,
    output logic [1:0]        dbg_state
);
    localparam int IW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("i2c_arbiter: NREQ must be in 2..8");
    end
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 131071) begin : g_bad_timeout
        $error("i2c_arbiter: TIMEOUT_CYC must fit the 17-bit counter");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          state, state_nx;
    logic [IW-1:0]   ptr, gnt, sel_idx;
    logic            sel_found;
    logic            done_q, done_rise, wait_first;
    logic            eng_rw_q;
    logic [15:0]     eng_data_q;
    logic [7:0]      rsp_data_q, rsp_data_nx;
    logic            rsp_nack_q, rsp_nack_nx;
    logic            busy_q;
    logic            load_rsp;
    logic [NREQ-1:0] rsp_valid_c;

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a, input int b);
        int s;
        s = int'(a) + b;
        if (s >= NREQ) s = s - NREQ;
        return IW'(s);
    endfunction

    assign done_rise = bus.eng_done & ~done_q;

    // First pending requester at or after ptr, wrapping around
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int off = 0; off < NREQ; off++) begin
            if (!sel_found && bus.req_valid[wrap_add(ptr, off)]) begin
                sel_found = 1'b1;
                sel_idx   = wrap_add(ptr, off);
            end
        end
    end

`ifdef I2C_TIMEOUT_EN
    logic [16:0] tmo_cnt;
    logic        tmo_hit;
    logic        rsp_err_q, rsp_err_nx;

    // True on the TIMEOUT_CYC-th WAIT cycle
    assign tmo_hit = (tmo_cnt >= 17'(TIMEOUT_CYC - 1));
`endif

    always_comb begin
        state_nx    = state;
        load_rsp    = 1'b0;
        rsp_data_nx = rsp_data_q;
        rsp_nack_nx = rsp_nack_q;
`ifdef I2C_TIMEOUT_EN
        rsp_err_nx  = rsp_err_q;
`endif
        unique case (state)
            S_IDLE:  if (sel_found) state_nx = S_ISSUE;
            S_ISSUE: state_nx = S_WAIT;
            S_WAIT: begin
                // The engine may still show a stale done level right after the strobe
                if (done_rise && !wait_first) begin
                    load_rsp    = 1'b1;
                    rsp_data_nx = bus.eng_data_out;
                    rsp_nack_nx = ~bus.eng_ack;
`ifdef I2C_TIMEOUT_EN
                    rsp_err_nx  = 1'b0;
`endif
                    state_nx    = S_RESP;
                end
`ifdef I2C_TIMEOUT_EN
                else if (tmo_hit) begin
                    load_rsp    = 1'b1;
                    rsp_data_nx = 8'h00;
                    rsp_nack_nx = 1'b1;
                    rsp_err_nx  = 1'b1;
                    state_nx    = S_RESP;
                end
`endif
            end
            S_RESP:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            ptr        <= '0;
            gnt        <= '0;
            done_q     <= 1'b0;
            wait_first <= 1'b0;
            eng_rw_q   <= 1'b0;
            eng_data_q <= '0;
            rsp_data_q <= '0;
            rsp_nack_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state      <= state_nx;
            done_q     <= bus.eng_done;
            wait_first <= (state == S_ISSUE);
            busy_q     <= (state_nx != S_IDLE);
            if (state == S_IDLE && sel_found) begin
                gnt        <= sel_idx;
                eng_rw_q   <= bus.req_rw[sel_idx];
                eng_data_q <= bus.req_data[{sel_idx, 4'b0000} +: 16];
            end
            if (load_rsp) begin
                rsp_data_q <= rsp_data_nx;
                rsp_nack_q <= rsp_nack_nx;
            end
            if (state == S_RESP) ptr <= wrap_add(gnt, 1);
        end
    end

`ifdef I2C_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt   <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            if (state == S_ISSUE)     tmo_cnt <= '0;
            else if (state == S_WAIT) tmo_cnt <= tmo_cnt + 17'd1;
            if (load_rsp) rsp_err_q <= rsp_err_nx;
        end
    end
    assign bus.rsp_err = rsp_err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif

    always_comb begin
        rsp_valid_c = '0;
        if (state == S_RESP) rsp_valid_c[gnt] = 1'b1;
    end

    assign bus.rsp_valid      = rsp_valid_c;
    assign bus.rsp_data       = rsp_data_q;
    assign bus.rsp_nack       = rsp_nack_q;
    assign bus.busy           = busy_q;
    assign bus.eng_startread  = (state == S_ISSUE) &  eng_rw_q;
    assign bus.eng_startwrite = (state == S_ISSUE) & ~eng_rw_q;
    assign bus.eng_rw         = eng_rw_q;
    assign bus.eng_data       = eng_data_q;
    assign dbg_state          = state;
endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed bench for i2c_arbiter: single write/read, contention order, NACK, first-WAIT guard,
// reset mid-transfer and (with I2C_TIMEOUT_EN) the eng_done watchdog.
module tb_i2c_arbiter;
  localparam int NREQ = 4;
  localparam int TMO  = 100;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] dbg_state;
  int n_checks = 0;
  int n_errors = 0;

  logic [NREQ-1:0] exp_q[$];
  logic [15:0]     exp_data_q[$];

  int              lat;
  logic            rd, wr;
  logic [15:0]     d;
  logic [NREQ-1:0] rv;
  logic [NREQ-1:0] e_rv;
  logic [15:0]     e_d;
  int              n;

  i2c_arbiter_if #(.NREQ(NREQ)) bus();

  i2c_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic set_req(input int i, input logic v, input logic rw, input logic [15:0] data);
    bus.req_valid[i] = v;
    bus.req_rw[i] = rw;
    bus.req_data[16*i +: 16] = data;
  endtask

  // Engine model: waits for a start strobe, raises eng_done dly cycles later, returns in the RESP cycle
  task automatic serve(input int dly, input logic ack, input logic [7:0] dout,
                       output int l, output logic srd, output logic swr,
                       output logic [15:0] sdata, output logic [NREQ-1:0] srv);
    int extra;
    logic [NREQ-1:0] early;
    l = 0; srd = 1'b0; swr = 1'b0; sdata = '0; srv = '0; extra = 0; early = '0;
    while (!(bus.eng_startread || bus.eng_startwrite) && l < 10) begin
      tick();
      l++;
    end
    if (l >= 10) begin
      check("strobe_wait_expired", 32'(l), 32'd0);
      return;
    end
    srd = bus.eng_startread;
    swr = bus.eng_startwrite;
    sdata = bus.eng_data;
    bus.eng_ack = ack;
    bus.eng_data_out = dout;
    for (int k = 0; k < dly; k++) begin
      tick();
      if (bus.eng_startread || bus.eng_startwrite) extra++;
      early |= bus.rsp_valid;
    end
    bus.eng_done = 1'b1;
    tick();
    srv = bus.rsp_valid;
    bus.eng_done = 1'b0;
    check("single_strobe_cycle", 32'(extra), 32'd0);
    check("no_early_rsp", 32'(early), 32'd0);
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_rw = '0;
    bus.req_data = '0;
    bus.eng_done = 1'b0;
    bus.eng_ack = 1'b0;
    bus.eng_data_out = '0;

    // reset state
    repeat (3) tick();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_strobes", 32'({bus.eng_startread, bus.eng_startwrite}), 32'd0);
    check("rst_eng_rw", 32'(bus.eng_rw), 32'd0);
    check("rst_eng_data", 32'(bus.eng_data), 32'd0);
    check("rst_rsp", 32'({bus.rsp_data, bus.rsp_nack, bus.rsp_err}), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    reset = 1'b0;
    tick();

    // single write from requester 0, done 20 cycles after the strobe
    set_req(0, 1'b1, 1'b0, 16'h3A55);
    serve(20, 1'b1, 8'hEE, lat, rd, wr, d, rv);
    check("wr_latency", 32'(lat), 32'd1);
    check("wr_strobe", 32'({rd, wr}), 32'b01);
    check("wr_eng_data", 32'(d), 32'h3A55);
    check("wr_rsp_valid", 32'(rv), 32'b0001);
    check("wr_nack", 32'(bus.rsp_nack), 32'd0);
    check("wr_err", 32'(bus.rsp_err), 32'd0);
    check("wr_rsp_data", 32'(bus.rsp_data), 32'hEE);
    check("wr_busy_resp", 32'(bus.busy), 32'd1);
    set_req(0, 1'b0, 1'b0, 16'h0000);
    tick();
    check("wr_rsp_one_cycle", 32'(bus.rsp_valid), 32'd0);
    check("wr_idle_busy", 32'(bus.busy), 32'd0);
    check("wr_rsp_hold", 32'(bus.rsp_data), 32'hEE);

    // read from requester 2
    set_req(2, 1'b1, 1'b1, 16'h9012);
    serve(5, 1'b1, 8'hC3, lat, rd, wr, d, rv);
    check("rd_strobe", 32'({rd, wr}), 32'b10);
    check("rd_eng_data", 32'(d), 32'h9012);
    check("rd_eng_rw", 32'(bus.eng_rw), 32'd1);
    check("rd_rsp_valid", 32'(rv), 32'b0100);
    check("rd_rsp_data", 32'(bus.rsp_data), 32'hC3);
    check("rd_nack", 32'(bus.rsp_nack), 32'd0);
    set_req(2, 1'b0, 1'b0, 16'h0000);
    tick();

    // reset while in WAIT; ptr was 3, so afterwards requester 0 must win over 3
    set_req(3, 1'b1, 1'b0, 16'h4444);
    tick();
    check("rw_strobe_grant3", 32'({bus.eng_startwrite, bus.eng_data}), 32'h1_4444);
    tick();
    tick();
    check("rw_in_wait", 32'(dbg_state), 32'd2);
    reset = 1'b1;
    set_req(3, 1'b0, 1'b0, 16'h0000);
    tick();
    check("rw_busy", 32'(bus.busy), 32'd0);
    check("rw_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rw_strobes", 32'({bus.eng_startread, bus.eng_startwrite}), 32'd0);
    check("rw_state", 32'(dbg_state), 32'd0);
    check("rw_rsp_data", 32'(bus.rsp_data), 32'd0);
    reset = 1'b0;
    set_req(0, 1'b1, 1'b0, 16'h0A0A);
    set_req(3, 1'b1, 1'b0, 16'h3B3B);
    serve(3, 1'b1, 8'h11, lat, rd, wr, d, rv);
    check("rw_first_grant", 32'(rv), 32'b0001);
    check("rw_first_data", 32'(d), 32'h0A0A);
    set_req(0, 1'b0, 1'b0, 16'h0000);
    serve(3, 1'b1, 8'h12, lat, rd, wr, d, rv);
    check("rw_second_grant", 32'(rv), 32'b1000);
    set_req(3, 1'b0, 1'b0, 16'h0000);
    tick();

    // contention: 4'b1011 held from reset -> 0,1,3,0
    reset = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      if (i != 2) set_req(i, 1'b1, 1'b0, 16'hA0B0 + 16'(i));
    end
    repeat (2) tick();
    reset = 1'b0;
    exp_q = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
    exp_data_q = '{16'hA0B0, 16'hA0B1, 16'hA0B3, 16'hA0B0};
    for (int g = 0; g < 4; g++) begin
      serve(4, 1'b1, 8'h20 + 8'(g), lat, rd, wr, d, rv);
      e_rv = exp_q.pop_front();
      e_d = exp_data_q.pop_front();
      check("cont_rsp_valid", 32'(rv), 32'(e_rv));
      check("cont_eng_data", 32'(d), 32'(e_d));
      check("cont_strobe", 32'({rd, wr}), 32'b01);
    end
    bus.req_valid = '0;
    tick();

    // NACK from requester 1 (ptr=1), then ptr must have moved to 2
    set_req(1, 1'b1, 1'b0, 16'h5151);
    serve(6, 1'b0, 8'h5A, lat, rd, wr, d, rv);
    check("nack_rsp_valid", 32'(rv), 32'b0010);
    check("nack_flag", 32'(bus.rsp_nack), 32'd1);
    check("nack_err", 32'(bus.rsp_err), 32'd0);
    check("nack_rsp_data", 32'(bus.rsp_data), 32'h5A);
    set_req(1, 1'b0, 1'b0, 16'h0000);
    tick();
    check("nack_hold", 32'(bus.rsp_nack), 32'd1);
    set_req(1, 1'b1, 1'b0, 16'h1111);
    set_req(2, 1'b1, 1'b0, 16'h2222);
    serve(3, 1'b1, 8'h66, lat, rd, wr, d, rv);
    check("ptr_adv_grant", 32'(rv), 32'b0100);
    check("ptr_adv_data", 32'(d), 32'h2222);
    check("ack_clears_nack", 32'(bus.rsp_nack), 32'd0);
    set_req(2, 1'b0, 1'b0, 16'h0000);
    serve(3, 1'b1, 8'h77, lat, rd, wr, d, rv);
    check("ptr_adv_second", 32'(rv), 32'b0010);
    set_req(1, 1'b0, 1'b0, 16'h0000);
    tick();

    // done edge during the first WAIT cycle is ignored
    set_req(2, 1'b1, 1'b1, 16'h7E7E);
    bus.eng_ack = 1'b1;
    bus.eng_data_out = 8'h99;
    tick();
    check("guard_strobe", 32'(bus.eng_startread), 32'd1);
    tick();
    bus.eng_done = 1'b1;
    tick();
    check("guard_ignored", 32'(bus.rsp_valid), 32'd0);
    bus.eng_done = 1'b0;
    tick();
    tick();
    bus.eng_done = 1'b1;
    tick();
    check("guard_late_done", 32'(bus.rsp_valid), 32'b0100);
    check("guard_rsp_data", 32'(bus.rsp_data), 32'h99);
    bus.eng_done = 1'b0;
    set_req(2, 1'b0, 1'b0, 16'h0000);
    tick();

`ifdef I2C_TIMEOUT_EN
    // eng_done stuck low: RESP after exactly TMO WAIT cycles
    set_req(0, 1'b1, 1'b1, 16'h0F0F);
    tick();
    check("tmo_strobe", 32'(bus.eng_startread), 32'd1);
    n = 0;
    while (bus.rsp_valid == '0 && n < 3 * TMO) begin
      tick();
      n++;
    end
    check("tmo_cycles", 32'(n), 32'(TMO + 1));
    check("tmo_rsp_valid", 32'(bus.rsp_valid), 32'b0001);
    check("tmo_err", 32'(bus.rsp_err), 32'd1);
    check("tmo_nack", 32'(bus.rsp_nack), 32'd1);
    check("tmo_rsp_data", 32'(bus.rsp_data), 32'h00);
    set_req(0, 1'b0, 1'b0, 16'h0000);
    tick();
    set_req(1, 1'b1, 1'b0, 16'h1234);
    serve(4, 1'b1, 8'h42, lat, rd, wr, d, rv);
    check("tmo_recover_rv", 32'(rv), 32'b0010);
    check("tmo_recover_err", 32'(bus.rsp_err), 32'd0);
    set_req(1, 1'b0, 1'b0, 16'h0000);
    tick();
`endif

    check("final_idle", 32'({bus.busy, dbg_state}), 32'd0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
